i2osp: RTL and testbench
========================

Name: i2osp

Overview:
- Converts a nonnegative integer into an octet string of requested length xLen, per PKCS#1 I2OSP. It is the inverse of the OS2IP encoder.
- Sits on the RSA output path, after modular exponentiation and before the network/packet framer.
- Captures the integer in one handshake, range-checks it against xLen, then streams octets MSB-first, one per cycle, with valid/ready backpressure.
- Flags "integer too large" instead of emitting a truncated string.

Parameters:
- DATA_BIT_WIDTH, 2048, width of the integer bus; must be a multiple of 8.
- MAX_OCTETS, DATA_BIT_WIDTH/8, largest legal xLen (256 by default).
- LEN_WIDTH, $clog2(MAX_OCTETS)+1, width of x_len (9 by default).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- valid  in  1  request strobe; x and x_len are valid.
- in_ready  out  1  block can accept a request.
- x  in  DATA_BIT_WIDTH  nonnegative integer, LSB at bit 0.
- x_len  in  LEN_WIDTH  requested output length in octets.
- o_valid  out  1  o_octet is valid.
- o_ready  in  1  downstream accepts o_octet.
- o_octet  out  8  current octet; first octet is the most significant.
- o_last  out  1  marks the final octet of the string; qualified by o_valid.
- o_error  out  1  one-cycle pulse: x >= 256^x_len, or x_len is out of range.

Behaviour:
- Reset (async, reset_n=0) forces the following, effective immediately, with any in-progress string discarded:
  - state=IDLE
  - in_ready=1
  - o_valid=0, o_last=0, o_error=0
  - o_octet=0
  - octet counter=0, shift register=0
- States: IDLE, CHECK, EMIT, ERR.
- IDLE:
  - in_ready=1.
  - When valid && in_ready: register x into the shift register and x_len into the counter; go to CHECK.
  - valid while not in IDLE is ignored (in_ready=0).
- CHECK (exactly one cycle, in_ready=0, o_valid=0):
  - error if x_len==0, or x_len>MAX_OCTETS, or any bit of x at index >= 8*x_len is set.
  - On error, go to ERR.
  - Otherwise left-align the register: sreg <= sreg << 8*(MAX_OCTETS-x_len). Go to EMIT.
- ERR (one cycle):
  - o_error=1, o_valid=0.
  - Next state IDLE; in_ready returns to 1 on the following cycle.
- EMIT:
  - o_valid=1; o_octet=sreg[DATA_BIT_WIDTH-1 -: 8]; o_last=(counter==1).
  - On o_valid && o_ready: sreg <<= 8 and counter decrements.
  - If o_last was set, go to IDLE.
  - While o_ready=0, o_octet and o_last are held stable and o_valid stays 1; no octet is dropped or repeated.
- Latency:
  - Request accepted at edge N; first octet is valid after edge N+2.
  - With o_ready held at 1, a string of xLen octets completes in xLen cycles.
  - in_ready is reasserted the cycle after the last handshake.
  - Error path: o_error is high for the cycle after edge N+2; no octet is ever emitted.
- Leading zeros: when x < 256^(x_len-1), the leading octets are 0x00, exactly as PKCS#1 requires.
- Width rules:
  - Shift amounts are computed at LEN_WIDTH+3 bits minimum.
  - The range check compares against a mask built from x_len, never a 256^x_len multiplier.
- Boundaries:
  - x_len==MAX_OCTETS: no range error is possible; shift by 0.
  - x==0 with x_len>0: all-zero string.
  - x_len==1: the first octet is also o_last.
- Reset deasserted mid-stream: the block restarts in IDLE; the downstream consumer must treat a string without o_last as aborted.
- No internal queuing; the block handles one request at a time.

Test Plan:
- x=0x0102, x_len=4, o_ready=1 → octets 00,00,01,02 on four consecutive cycles; o_last only on 02; first octet 2 cycles after accept.
- x=0x10000, x_len=2 → o_error pulse for 1 cycle, o_valid never asserts, in_ready returns 1; then x_len=0 → o_error; then x_len=257 → o_error.
- x=all-ones (2048 bits), x_len=256, o_ready=1 → 256 octets of 0xFF, o_last on the 256th, no error.
- x=0xA1B2C3, x_len=3, o_ready toggled pseudo-randomly → sequence A1,B2,C3 exactly once each; each octet stable while o_ready=0.
- reset_n pulsed low after the 2nd octet of an 8-octet string → all outputs 0 asynchronously, in_ready=1 after release; a new request x=0x55, x_len=1 yields single octet 55 with o_last.
- Back-to-back requests, valid held high → the second request is accepted only on the cycle in_ready=1 after the first o_last handshake; valid seen while busy produces no extra output.

Source files
------------

// File: rtl/i2osp.sv
// i2osp: integer-to-octet-string converter (PKCS#1 I2OSP).
// Captures a DATA_BIT_WIDTH integer and a requested length, rejects integers
// that do not fit in x_len octets, and otherwise streams the octets MSB-first
// with valid/ready flow control on the output side.
module i2osp #(
  parameter int DATA_BIT_WIDTH = 2048,
  parameter int MAX_OCTETS     = DATA_BIT_WIDTH / 8,
  parameter int LEN_WIDTH      = $clog2(MAX_OCTETS) + 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      valid,
  output logic                      in_ready,
  input  logic [DATA_BIT_WIDTH-1:0] x,
  input  logic [LEN_WIDTH-1:0]      x_len,
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic [7:0]                o_octet,
  output logic                      o_last,
  output logic                      o_error
);

  // Bit-level shift amounts need three extra bits over the octet count.
  localparam int SH_W = LEN_WIDTH + 3;
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_OCTETS);

  typedef enum logic [1:0] {IDLE, CHECK, EMIT, ERR} state_t;

  state_t                    state;
  logic [DATA_BIT_WIDTH-1:0] sreg;
  logic [LEN_WIDTH-1:0]      cnt;

  logic [SH_W-1:0]           len_bits;
  logic [SH_W-1:0]           align_bits;
  logic [DATA_BIT_WIDTH-1:0] hi_mask;
  logic                      len_bad;
  logic                      range_bad;

  // Range check and left-alignment amount, both derived from the captured length.
  // The mask covers every bit at index >= 8*len; any set bit there means the
  // integer does not fit.
  always_comb begin
    len_bits   = {cnt, 3'b000};
    align_bits = {MAX_LEN - cnt, 3'b000};
    hi_mask    = {DATA_BIT_WIDTH{1'b1}} << len_bits;
    len_bad    = (cnt == '0) || (cnt > MAX_LEN);
    range_bad  = |(sreg & hi_mask);
  end

  // Control FSM with registered outputs. In EMIT the next octet is prefetched
  // into o_octet whenever the output register is empty or being consumed, so
  // a held o_ready=1 yields one octet per cycle. ERR spends one cycle raising
  // o_error and one cycle lowering it before in_ready returns.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      in_ready <= 1'b1;
      o_valid  <= 1'b0;
      o_last   <= 1'b0;
      o_error  <= 1'b0;
      o_octet  <= 8'h00;
      cnt      <= '0;
      sreg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid && in_ready) begin
            sreg     <= x;
            cnt      <= x_len;
            in_ready <= 1'b0;
            state    <= CHECK;
          end
        end

        CHECK: begin
          if (len_bad || range_bad) begin
            state <= ERR;
          end else begin
            sreg  <= sreg << align_bits;
            state <= EMIT;
          end
        end

        EMIT: begin
          if (!o_valid || o_ready) begin
            if (o_valid && o_last) begin
              o_valid  <= 1'b0;
              o_last   <= 1'b0;
              in_ready <= 1'b1;
              state    <= IDLE;
            end else begin
              o_valid <= 1'b1;
              o_octet <= sreg[DATA_BIT_WIDTH-1 -: 8];
              o_last  <= (cnt == LEN_WIDTH'(1));
              sreg    <= sreg << 8;
              cnt     <= cnt - LEN_WIDTH'(1);
            end
          end
        end

        ERR: begin
          if (!o_error) begin
            o_error <= 1'b1;
          end else begin
            o_error  <= 1'b0;
            in_ready <= 1'b1;
            state    <= IDLE;
          end
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2osp.sv
// Bench for i2osp: a queue-based reference model predicts the octet string
// (or an error) for every accepted request; one negedge process compares the
// DUT against it every cycle. Directed scenarios add literal expectations.
module tb_i2osp;

  localparam int DW   = 2048;
  localparam int MAXO = 256;
  localparam int LW   = 9;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          valid;
  logic          in_ready;
  logic [DW-1:0] x;
  logic [LW-1:0] x_len;
  logic          o_valid;
  logic          o_ready;
  logic [7:0]    o_octet;
  logic          o_last;
  logic          o_error;

  i2osp #(.DATA_BIT_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n), .valid(valid), .in_ready(in_ready),
    .x(x), .x_len(x_len), .o_valid(o_valid), .o_ready(o_ready),
    .o_octet(o_octet), .o_last(o_last), .o_error(o_error)
  );

  always #5 clk = ~clk;

  // Counters and model state (written only by the compare process)
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [8:0] exp_q[$];   // {last, octet}
  logic [8:0] obs_q[$];   // octets actually handed over
  int err_pend = 0;
  int err_seen = 0;
  int acc_edge = 0, first_edge = 0, last_edge = -100, err_edge = 0, acc_gap = 0;
  logic want_first = 0;
  logic prev_stall = 0, prev_last_hs = 0, prev_err = 0;
  logic [7:0] prev_octet = 0;
  logic prev_last = 0;

  // Directed expectations queued by the stimulus process
  string       req_name[256];
  logic [31:0] req_act[256];
  logic [31:0] req_exp[256];
  int wr = 0;
  int rd = 0;
  int rnd_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  task automatic req(input string n, input logic [31:0] a, input logic [31:0] e);
    req_name[wr % 256] = n;
    req_act[wr % 256]  = a;
    req_exp[wr % 256]  = e;
    wr++;
  endtask

  // Per-cycle compare against the reference model
  always @(negedge clk) begin
    while (rd < wr) begin
      chk(req_name[rd % 256], req_act[rd % 256], req_exp[rd % 256]);
      rd++;
    end
    if (!reset_n) begin
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_o_valid", 32'(o_valid), 0);
      chk("rst_o_last", 32'(o_last), 0);
      chk("rst_o_error", 32'(o_error), 0);
      chk("rst_o_octet", 32'(o_octet), 0);
      exp_q.delete();
      err_pend = 0;
      prev_stall = 0; prev_last_hs = 0; prev_err = 0; want_first = 0;
    end else begin
      if (prev_last_hs) chk("in_ready_after_last", 32'(in_ready), 1);
      if (prev_err) begin
        chk("error_one_cycle", 32'(o_error), 0);
        chk("in_ready_after_error", 32'(in_ready), 1);
      end
      if (prev_stall) begin
        chk("stall_valid_held", 32'(o_valid), 1);
        chk("stall_octet_held", 32'(o_octet), 32'(prev_octet));
        chk("stall_last_held", 32'(o_last), 32'(prev_last));
      end
      if (exp_q.size() > 0 || err_pend > 0) chk("busy_in_ready_low", 32'(in_ready), 0);
      if (o_error) begin
        chk("error_expected", 32'(err_pend > 0), 1);
        if (err_pend > 0) err_pend--;
        err_seen++;
        err_edge = cyc;
      end
      if (o_valid) begin
        if (want_first) begin
          first_edge = cyc;
          want_first = 0;
        end
        if (exp_q.size() == 0) begin
          chk("unexpected_o_valid", 32'(o_octet), 32'hFFFF_FFFF);
        end else begin
          chk("octet", 32'(o_octet), 32'(exp_q[0][7:0]));
          chk("last", 32'(o_last), 32'(exp_q[0][8]));
          if (o_ready) begin
            void'(exp_q.pop_front());
            obs_q.push_back({o_last, o_octet});
            if (o_last) last_edge = cyc + 1;
          end
        end
      end
      prev_stall   = o_valid && !o_ready;
      prev_octet   = o_octet;
      prev_last    = o_last;
      prev_last_hs = o_valid && o_ready && o_last;
      prev_err     = o_error;
      // Reference model: decide the whole string when the request is taken
      if (valid && in_ready) begin
        int l;
        l = int'(x_len);
        acc_edge = cyc + 1;
        acc_gap = acc_edge - last_edge;
        if (l == 0 || l > MAXO || ((x >> (8 * l)) != '0)) begin
          err_pend++;
        end else begin
          want_first = 1;
          for (int i = l - 1; i >= 0; i--) exp_q.push_back({(i == 0), x[8*i +: 8]});
        end
      end
    end
  end

  // Downstream ready: constant 1 or pseudo-random
  initial begin
    o_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      o_ready = (rnd_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send(input logic [DW-1:0] xv, input int l);
    int t;
    @(posedge clk);
    #1;
    valid = 1'b1; x = xv; x_len = LW'(l);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 3000);
    if (!in_ready) req("timeout_accept", 0, 1);
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while (!(exp_q.size() == 0 && err_pend == 0 && in_ready) && t < 3000);
    if (t >= 3000) req("timeout_done", 0, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] xv;
    int base, e0, nbad, l, nb, r;
    reset_n = 1'b0; valid = 1'b0; x = '0; x_len = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // 0x0102 in 4 octets: 00 00 01 02, first octet two edges after accept
    base = obs_q.size();
    xv = '0; xv[31:0] = 32'h0102;
    send(xv, 4);
    wait_done();
    req("t1_count", 32'(obs_q.size() - base), 4);
    req("t1_o0", 32'(obs_q[base]), 32'h000);
    req("t1_o1", 32'(obs_q[base+1]), 32'h000);
    req("t1_o2", 32'(obs_q[base+2]), 32'h001);
    req("t1_o3", 32'(obs_q[base+3]), 32'h102);
    req("t1_first_latency", 32'(first_edge - acc_edge), 2);
    req("t1_last_latency", 32'(last_edge - acc_edge), 6);

    // Error cases: too large, zero length, length above maximum
    base = obs_q.size(); e0 = err_seen;
    xv = '0; xv[31:0] = 32'h10000;
    send(xv, 2);
    wait_done();
    req("t2_err_latency", 32'(err_edge - acc_edge), 2);
    req("t2_err_large", 32'(err_seen - e0), 1);
    send(xv, 0);
    wait_done();
    req("t2_err_len0", 32'(err_seen - e0), 2);
    send(xv, 257);
    wait_done();
    req("t2_err_len257", 32'(err_seen - e0), 3);
    req("t2_no_octets", 32'(obs_q.size() - base), 0);

    // Full-width all-ones integer at maximum length
    base = obs_q.size(); e0 = err_seen;
    xv = '1;
    send(xv, 256);
    wait_done();
    nbad = 0;
    for (int i = 0; i < 256; i++)
      if (obs_q.size() > base + i && obs_q[base+i][7:0] != 8'hFF) nbad++;
    req("t3_count", 32'(obs_q.size() - base), 256);
    req("t3_all_ff", 32'(nbad), 0);
    req("t3_last_flag", 32'(obs_q[obs_q.size()-1]), 32'h1FF);
    req("t3_no_error", 32'(err_seen - e0), 0);

    // Random backpressure on a 3-octet string
    rnd_mode = 1;
    base = obs_q.size();
    xv = '0; xv[31:0] = 32'hA1B2C3;
    send(xv, 3);
    wait_done();
    req("t4_count", 32'(obs_q.size() - base), 3);
    req("t4_o0", 32'(obs_q[base]), 32'h0A1);
    req("t4_o1", 32'(obs_q[base+1]), 32'h0B2);
    req("t4_o2", 32'(obs_q[base+2]), 32'h1C3);
    rnd_mode = 0;

    // Asynchronous reset after the second octet of an 8-octet string
    base = obs_q.size();
    xv = '0; xv[63:0] = 64'h0102030405060708;
    send(xv, 8);
    begin
      int t;
      t = 0;
      while (obs_q.size() < base + 2 && t < 100) begin
        @(negedge clk);
        #1;
        t++;
      end
      if (t >= 100) req("timeout_t5", 0, 1);
    end
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    req("t5_async_valid", 32'(o_valid), 0);
    req("t5_async_last", 32'(o_last), 0);
    req("t5_async_octet", 32'(o_octet), 0);
    req("t5_async_error", 32'(o_error), 0);
    req("t5_async_in_ready", 32'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    req("t5_aborted_count", 32'(obs_q.size() - base), 2);
    xv = '0; xv[7:0] = 8'h55;
    send(xv, 1);
    wait_done();
    req("t5_new_count", 32'(obs_q.size() - base), 3);
    req("t5_new_octet", 32'(obs_q[base+2]), 32'h155);

    // Back-to-back requests with valid held high
    base = obs_q.size();
    @(posedge clk);
    #1;
    valid = 1'b1; x = '0; x[15:0] = 16'h1234; x_len = LW'(2);
    @(posedge clk);
    #1;
    x = '0; x[7:0] = 8'hAB; x_len = LW'(1);
    begin
      int t;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!in_ready && t < 100);
      if (!in_ready) req("timeout_t6", 0, 1);
    end
    @(posedge clk);
    #1 valid = 1'b0;
    wait_done();
    req("t6_count", 32'(obs_q.size() - base), 3);
    req("t6_o0", 32'(obs_q[base]), 32'h012);
    req("t6_o1", 32'(obs_q[base+1]), 32'h134);
    req("t6_o2", 32'(obs_q[base+2]), 32'h1AB);
    req("t6_accept_gap", 32'(acc_gap), 1);

    // Randomized requests, checked by the per-cycle model
    rnd_mode = 1;
    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(0, 19);
      if (r == 0) l = 0;
      else if (r == 1) l = 257 + $urandom_range(0, 254);
      else if (r == 2) l = 256;
      else l = $urandom_range(1, 12);
      nb = (l >= 1 && l <= 256) ? l + (($urandom_range(0, 3) == 0) ? 1 : 0) : 4;
      xv = '0;
      if (r != 3)
        for (int i = 0; i < nb && i < 256; i++) xv[8*i +: 8] = 8'($urandom);
      send(xv, l);
      wait_done();
    end
    rnd_mode = 0;

    repeat (3) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
